// File: rtl/dmem_bridge.sv
// ---------------------------------------------------------------------------
// dmem_bridge
//
// Data-side memory bridge between the MEM pipeline stage and an SRAM-like
// data bus. Each load/store from the MEM stage becomes exactly one bus
// transaction over a req / addr_ok / data_ok handshake. The bridge stalls
// the pipeline until the data phase completes. It holds the load result
// while the pipeline is frozen by other stall sources. A watchdog aborts a
// transaction that the bus never answers.
//
// Parameters
//   TIMEOUT_CYCLES  Number of bus-wait cycles before an abort. The counter is
//                   16 bits wide. A value of 0 disables the watchdog.
//
// Optional feature (compile-time macro)
//   DMEM_RDATA_BYPASS_EN  When defined, the completing data_rdata goes
//                         straight to cpu_rdata and cpu_stall drops in the
//                         data_ok cycle. This saves one cycle of load latency.
//                         When undefined, cpu_rdata is always registered.
//
// Ports
//   clk, rst          Clock (rising edge) and asynchronous active-low reset.
//   cpu_en            MEM stage holds a valid load/store this cycle.
//   cpu_wr            1 = store, 0 = load.
//   cpu_size          0 byte, 1 half, 2 word. 3 is treated as word.
//   cpu_paddr         Physical address from the MMU.
//   cpu_wdata         Store data, already lane-aligned.
//   cpu_hold          Pipeline frozen by another stall source.
//   cpu_stall         Pipeline must not advance. Combinational.
//   cpu_rdata         Load result. Zero for stores and for aborted accesses.
//   bus_err           One-cycle pulse on a watchdog abort.
//   data_req/wr/size/addr/wdata   Bus request channel (registered).
//   data_addr_ok      Bus accepted the request this cycle.
//   data_data_ok      Bus completed the data phase this cycle.
//   data_rdata        Read data. Valid together with data_data_ok.
// ---------------------------------------------------------------------------
module dmem_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_size,
  input  logic [31:0] cpu_paddr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_hold,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        bus_err,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);

  state_e      state_q;
  logic [15:0] wd_cnt_q;
  logic [31:0] rdata_q;
  logic        bus_err_q;
  logic        req_q;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        busy;
  logic        data_done;
  logic        wd_fire;
  logic [31:0] rdata_cap;

  assign busy = (state_q == S_REQ) || (state_q == S_WAIT);

  // The data phase completes in WAIT on data_ok, or in REQ only when the
  // request is accepted in the same cycle. A data_ok that arrives in REQ
  // without addr_ok belongs to no request of ours, so it is ignored.
  assign data_done = ((state_q == S_WAIT) && data_data_ok) ||
                     ((state_q == S_REQ) && data_addr_ok && data_data_ok);

  // The counter holds the number of wait cycles already spent. The abort
  // fires during the TIMEOUT-th wait cycle. A completion in that same cycle
  // takes priority over the abort.
  assign wd_fire = WD_EN && busy && !data_done &&
                   (wd_cnt_q == (TIMEOUT - 16'd1));

  // The bus returns garbage on a store, so the captured word is zeroed.
  assign rdata_cap = wr_q ? 32'h0 : data_rdata;

  // NOTE: Sequential state uses non-blocking assignments only. This way every
  // register in this block samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wd_cnt_q  <= 16'd0;
      rdata_q   <= 32'h0;
      bus_err_q <= 1'b0;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= 2'd0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
    end else begin
      bus_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_en) begin
            wr_q     <= cpu_wr;
            size_q   <= (cpu_size == 2'd3) ? 2'd2 : cpu_size;
            addr_q   <= cpu_paddr;
            wdata_q  <= cpu_wdata;
            req_q    <= 1'b1;
            wd_cnt_q <= 16'd0;
            state_q  <= S_REQ;
          end
        end

        S_REQ, S_WAIT: begin
          wd_cnt_q <= wd_cnt_q + 16'd1;
          if (data_done) begin
            req_q   <= 1'b0;
            rdata_q <= rdata_cap;
`ifdef DMEM_RDATA_BYPASS_EN
            // The word was already handed over combinationally. DONE is
            // needed only if the pipeline cannot take it this cycle.
            state_q <= cpu_hold ? S_DONE : S_IDLE;
`else
            state_q <= S_DONE;
`endif
          end else if (wd_fire) begin
            req_q     <= 1'b0;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b1;
            state_q   <= S_DONE;
          end else if ((state_q == S_REQ) && data_addr_ok) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end

        S_DONE: begin
          if (!cpu_hold) begin
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // NOTE: Every output of a combinational block gets a default first. A path
  // that forgets to assign it would otherwise infer a latch.
  always_comb begin
    cpu_stall = 1'b0;
    case (state_q)
      S_IDLE:         cpu_stall = cpu_en;
      S_REQ, S_WAIT:  cpu_stall = 1'b1;
      default:        cpu_stall = 1'b0;
    endcase
`ifdef DMEM_RDATA_BYPASS_EN
    if (data_done) begin
      cpu_stall = 1'b0;
    end
`endif
    // During reset every output reads 0, including this combinational one.
    if (!rst) begin
      cpu_stall = 1'b0;
    end
  end

`ifdef DMEM_RDATA_BYPASS_EN
  assign cpu_rdata = data_done ? rdata_cap : rdata_q;
`else
  assign cpu_rdata = rdata_q;
`endif

  assign bus_err    = bus_err_q;
  assign data_req   = req_q;
  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// ---------------------------------------------------------------------------
// tb_dmem_bridge
//
// Self-checking bench for dmem_bridge, instantiated with TIMEOUT_CYCLES = 8.
// A table of accesses drives the main flow. Each table entry gives the
// access, the number of addr_ok and data_ok wait cycles, the bus read data,
// and the number of hold cycles after completion. Expected results are pushed
// to a scoreboard queue when an access is presented. They are popped when the
// bridge releases the stall. Hand-written sequences cover the reset, the
// watchdog abort and late-response corner cases.
// ---------------------------------------------------------------------------
module tb_dmem_bridge;

  localparam int TO = 8;
`ifdef DMEM_RDATA_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en, cpu_wr, cpu_hold;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_paddr, cpu_wdata;
  logic        cpu_stall, bus_err;
  logic [31:0] cpu_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;

  always #5 clk = ~clk;

  dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_en       (cpu_en),
    .cpu_wr       (cpu_wr),
    .cpu_size     (cpu_size),
    .cpu_paddr    (cpu_paddr),
    .cpu_wdata    (cpu_wdata),
    .cpu_hold     (cpu_hold),
    .cpu_stall    (cpu_stall),
    .cpu_rdata    (cpu_rdata),
    .bus_err      (bus_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;  // word the bus returns on data_ok
    int          aw;     // addr_ok wait cycles
    int          dw;     // data_ok wait cycles after acceptance
    int          hold;   // cpu_hold cycles after completion
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    int          done_c;
  } exp_t;

  vec_t vecs[7];
  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_en       = 1'b0;
    cpu_wr       = 1'b0;
    cpu_size     = 2'd0;
    cpu_paddr    = 32'h0;
    cpu_wdata    = 32'h0;
    cpu_hold     = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
  endtask

  // One access from the table. Cycle 0 presents the access in IDLE. Later
  // cycles keep cpu_en/cpu_hold asserted as a stalled pipeline would. The cpu
  // fields are scrambled to show that they cannot reach the bus.
  task automatic run_vec(input vec_t v, input int idx);
    int          exp_done, req_cycles, last_c;
    logic [31:0] exp_rd, bus_rd, held;
    logic [1:0]  exp_size;
    logic        fields_ok, req_ok, hold_ok, popped;
    exp_t        e;
    exp_done = (BYPASS ? 1 : 2) + v.aw + v.dw;
    last_c   = exp_done + v.hold;
    exp_rd   = v.wr ? 32'h0 : v.rdata;
    bus_rd   = (v.wr && BYPASS) ? 32'h0 : v.rdata;
    exp_size = (v.size == 2'd3) ? 2'd2 : v.size;

    @(negedge clk);
    cpu_en       = 1'b1;
    cpu_wr       = v.wr;
    cpu_size     = v.size;
    cpu_paddr    = v.addr;
    cpu_wdata    = v.wdata;
    cpu_hold     = 1'b1;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = $urandom;
    #1;
    check($sformatf("v%0d_c0_stall", idx), cpu_stall, 1'b1);
    check($sformatf("v%0d_c0_req", idx), data_req, 1'b0);
    e.rdata  = exp_rd;
    e.done_c = exp_done;
    sb_q.push_back(e);

    fields_ok  = 1'b1;
    req_ok     = 1'b1;
    hold_ok    = 1'b1;
    popped     = 1'b0;
    req_cycles = 0;
    held       = 32'h0;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      cpu_en       = (c < last_c);
      cpu_hold     = (c < last_c);
      cpu_wr       = ~v.wr;
      cpu_size     = ~v.size;
      cpu_paddr    = ~v.addr;
      cpu_wdata    = $urandom;
      data_addr_ok = (c == 1 + v.aw);
      // A stray data_ok in the first REQ cycle, before acceptance.
      data_data_ok = (c == 1 + v.aw + v.dw) || ((v.aw >= 2) && (c == 1));
      data_rdata   = (c == 1 + v.aw + v.dw) ? bus_rd : $urandom;
      #1;
      if (data_req === 1'b1) begin
        req_cycles++;
        if (data_addr !== v.addr || data_wr !== v.wr ||
            data_size !== exp_size || data_wdata !== v.wdata) fields_ok = 1'b0;
      end
      if (data_req !== (c <= 1 + v.aw)) req_ok = 1'b0;
      if (!popped && cpu_stall === 1'b0) begin
        popped = 1'b1;
        e = sb_q.pop_front();
        check($sformatf("v%0d_rdata", idx), cpu_rdata, e.rdata);
        check($sformatf("v%0d_done_cycle", idx), c, e.done_c);
        held = cpu_rdata;
      end else if (popped) begin
        if (cpu_stall !== 1'b0 || cpu_rdata !== held || bus_err !== 1'b0) hold_ok = 1'b0;
      end
    end
    check($sformatf("v%0d_completed", idx), popped, 1'b1);
    if (!popped) void'(sb_q.pop_front());
    check($sformatf("v%0d_req_fields_stable", idx), fields_ok, 1'b1);
    check($sformatf("v%0d_req_cycles", idx), req_cycles, v.aw + 1);
    check($sformatf("v%0d_req_window", idx), req_ok, 1'b1);
    check($sformatf("v%0d_hold_stable", idx), hold_ok, 1'b1);
  endtask

  // A load that the bus never accepts. The abort must happen TO cycles after
  // REQ entry. data_ok responses injected after the abort must be ignored.
  task automatic run_timeout();
    int   err_cnt, first_err;
    logic popped, late_ok, req_at_abort;
    exp_t e;
    @(negedge clk);
    idle_inputs();
    cpu_en    = 1'b1;
    cpu_size  = 2'd2;
    cpu_paddr = 32'h0000_4000;
    #1;
    e.rdata  = 32'h0;
    e.done_c = 1 + TO;
    sb_q.push_back(e);
    err_cnt      = 0;
    first_err    = -1;
    popped       = 1'b0;
    late_ok      = 1'b1;
    req_at_abort = 1'b1;
    for (int c = 1; c <= TO + 5; c++) begin
      @(negedge clk);
      cpu_en       = (c < 1 + TO);
      data_addr_ok = 1'b0;
      data_data_ok = (c >= TO + 1);
      data_rdata   = 32'h5A5A_5A5A;
      #1;
      if (bus_err === 1'b1) begin
        err_cnt++;
        if (first_err < 0) first_err = c;
      end
      if (c == TO + 1) req_at_abort = data_req;
      if (!popped && cpu_stall === 1'b0) begin
        popped = 1'b1;
        e = sb_q.pop_front();
        check("wd_rdata", cpu_rdata, e.rdata);
        check("wd_done_cycle", c, e.done_c);
      end else if (popped) begin
        if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0 || data_req !== 1'b0) late_ok = 1'b0;
      end
    end
    check("wd_completed", popped, 1'b1);
    if (!popped) void'(sb_q.pop_front());
    check("wd_bus_err_count", err_cnt, 1);
    check("wd_bus_err_cycle", first_err, 1 + TO);
    check("wd_req_dropped", req_at_abort, 1'b0);
    check("wd_late_data_ok_ignored", late_ok, 1'b1);
    @(negedge clk);
    idle_inputs();
  endtask

  // Reset asserted while the bridge waits for data_ok. Outputs must clear
  // immediately, without waiting for a clock edge.
  task automatic run_reset_mid();
    @(negedge clk);
    idle_inputs();
    cpu_en    = 1'b1;
    cpu_size  = 2'd2;
    cpu_paddr = 32'h0000_5000;
    @(negedge clk);            // REQ, accepted at once
    data_addr_ok = 1'b1;
    @(negedge clk);            // WAIT
    data_addr_ok = 1'b0;
    #1;
    check("rst_pre_stall", cpu_stall, 1'b1);
    @(negedge clk);            // still WAIT, reset hits mid-cycle
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_req", data_req, 1'b0);
    check("rst_mid_stall", cpu_stall, 1'b0);
    check("rst_mid_rdata", cpu_rdata, 32'h0);
    check("rst_mid_bus_err", bus_err, 1'b0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'h0000_0000, 32'hDEAD_BEEF, 0, 0, 0};
    vecs[1] = '{1'b1, 2'd0, 32'h1FC0_0003, 32'hA500_0000, 32'h1234_5678, 3, 2, 0};
    vecs[2] = '{1'b0, 2'd2, 32'h8000_0040, 32'h0000_0000, 32'hCAFE_F00D, 0, 1, 4};
    vecs[3] = '{1'b0, 2'd1, 32'h0000_2002, 32'h0000_0000, 32'h0000_BEEF, 1, 0, 0};
    vecs[4] = '{1'b1, 2'd1, 32'h0000_3000, 32'h0000_1234, 32'h7777_7777, 0, 3, 1};
    vecs[5] = '{1'b0, 2'd3, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0BAD_C0DE, 2, 2, 2};
    vecs[6] = '{1'b0, 2'd0, 32'h0000_0101, 32'h0000_0000, 32'h0000_00FF, 0, 0, 0};

    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_stall", cpu_stall, 1'b0);
    check("reset_rdata", cpu_rdata, 32'h0);
    check("reset_bus_err", bus_err, 1'b0);
    check("reset_req", data_req, 1'b0);
    check("reset_wr", data_wr, 1'b0);
    check("reset_size", data_size, 2'd0);
    check("reset_addr", data_addr, 32'h0);
    check("reset_wdata", data_wdata, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);
    run_timeout();
    run_vec(vecs[4], 4);
    run_vec(vecs[0], 0);       // leaves a nonzero word before the reset test
    run_reset_mid();
    for (int i = 5; i < 7; i++) run_vec(vecs[i], i);

    check("scoreboard_empty", sb_q.size(), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge between the MEM pipeline stage and the SRAM-like data bus. It consumes the translated physical address produced by the MMU (`d_paddr`) plus access attributes, and runs one bus transaction per access over a req/addr_ok/data_ok handshake. It stalls the pipeline until the data phase completes and holds the load result while the pipeline is held by other causes. A watchdog aborts transactions the bus never answers.

## Interface
- `TIMEOUT_CYCLES`, default 255: bus-wait cycles before abort; 16-bit counter; 0 disables the watchdog.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cpu_en` in 1: MEM stage holds a valid load/store this cycle.
- `cpu_wr` in 1: 1 = store, 0 = load.
- `cpu_size` in 2: 0 byte, 1 half, 2 word; 3 treated as word.
- `cpu_paddr` in 32: physical address from the MMU.
- `cpu_wdata` in 32: store data, already lane-aligned.
- `cpu_hold` in 1: pipeline frozen by another stall source.
- `cpu_stall` out 1: pipeline must not advance.
- `cpu_rdata` out 32: load result.
- `bus_err` out 1: one-cycle pulse on watchdog abort.
- `data_req` out 1, `data_wr` out 1, `data_size` out 2, `data_addr` out 32, `data_wdata` out 32: bus request channel.
- `data_addr_ok` in 1: request accepted this cycle.
- `data_data_ok` in 1: data phase complete this cycle.
- `data_rdata` in 32: read data, valid with `data_data_ok`.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on `cpu_en`, latch wr/size/paddr/wdata and go to REQ. `cpu_stall` = `cpu_en`.
- REQ: `data_req`=1 with latched fields. On `data_addr_ok`, go to WAIT. On `data_addr_ok` & `data_data_ok` together, capture `data_rdata` and go to DONE. `data_data_ok` without `data_addr_ok` is ignored.
- WAIT: `data_req`=0. On `data_data_ok`, capture rdata and go to DONE.
- DONE: `cpu_stall`=0; `cpu_rdata` holds the captured word. Stays in DONE while `cpu_hold`=1; returns to IDLE when `cpu_hold`=0.
  - For stores, the captured value is don't-care and is written as 0.
- `cpu_stall` = (IDLE & `cpu_en`) | REQ | WAIT.
- Watchdog: counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches `TIMEOUT_CYCLES` (nonzero): pulse `bus_err`, set captured rdata = 0, go to DONE, drop `data_req`.
  - A late `data_data_ok` arriving in IDLE or DONE is ignored.
- Request fields are stable while `data_req`=1; `cpu_*` changes during REQ/WAIT have no effect.
- Reset (asynchronous, any state): state IDLE; all outputs 0, including `data_req` and `cpu_rdata`; counter 0. An in-flight transaction is abandoned.

## Timing
- Zero-wait bus (`addr_ok` and `data_ok` in the first REQ cycle): access presented in cycle 0, REQ in cycle 1, DONE in cycle 2.
  - `cpu_stall` is high in cycles 0–1.
  - `cpu_rdata` is valid in cycle 2.
- Each `addr_ok` wait cycle and each `data_ok` wait cycle adds one cycle.
- Back-to-back accesses: DONE→IDLE→REQ, one idle bus cycle minimum between requests.
- All outputs are registered except `cpu_stall`, which is combinational on state and `cpu_en`.

## Configuration
- `DMEM_RDATA_BYPASS_EN` defined:
  - In WAIT (or REQ with both oks) with `data_data_ok`=1, `cpu_stall` drops that cycle and `cpu_rdata` = `data_rdata` combinationally.
  - If `cpu_hold`=0, the next state is IDLE; if `cpu_hold`=1, the data is captured and the next state is DONE.
  - Zero-wait latency becomes 2 cycles.
- Undefined: behaviour exactly as described above; `cpu_rdata` is always registered.

## Test plan
- Zero-wait load at `cpu_paddr`=0x0000_1000, bus returns 0xDEADBEEF with both oks in first REQ cycle → `data_req` in cycle 1 only; `cpu_stall` high cycles 0–1; `cpu_rdata`=0xDEADBEEF in cycle 2.
- Byte store, addr 0x1FC0_0003, `addr_ok` after 3 cycles, `data_ok` after 2 more → `data_size`=0, `data_wr`=1; addr/wdata stable through REQ; stall released 1 cycle after `data_ok`.
- Load completes while `cpu_hold`=1 for 4 cycles → state remains DONE, `cpu_rdata` is constant for 4 cycles, and `cpu_stall`=0 throughout.
- `TIMEOUT_CYCLES`=8, bus never asserts `addr_ok` → `bus_err` pulses once 8 cycles after REQ entry; `cpu_rdata`=0; a `data_ok` injected later is ignored.
- `rst` asserted in WAIT mid-transaction → `data_req`, `cpu_stall` and `cpu_rdata` go 0 immediately; after release, a new load completes normally.
- With `DMEM_RDATA_BYPASS_EN` defined, zero-wait load → `cpu_rdata` valid and `cpu_stall`=0 in cycle 1.
